// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: multiplexed seven-segment display bus.
//   an  : digit selects, active-low, one low bit selects a digit
//   seg : shared segments, active-low, seg[0]=a .. seg[6]=g, seg[7]=dp
// master = the display driver (or bench) driving the bus,
// slave  = a monitor such as seg_scan_capture observing it.
interface seg_scan_capture_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;

    modport master (output an, output seg);
    modport slave  (input  an, input  seg);
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reconstructs the digits shown on a multiplexed
// active-low seven-segment bus and publishes them as whole frames.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : an/seg display bus being monitored
//   value        : hex nibble per digit, digit k at [4k+3:4k]
//   points       : decimal point lit per digit
//   blank        : digit had all of a..g off
//   err          : digit showed an unrecognised a..g pattern
//   frame_valid  : one-cycle pulse when the outputs above update
//   frame_count  : frames published, wraps 255->0
module seg_scan_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_capture_if.slave     bus,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     points,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  frame_valid,
    output logic [7:0]            frame_count
);
    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ONE    = DIGITS'(1);

    // {err, blank, nibble} for an active-low {g..a} pattern
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 6'h00;
            7'b1111001: decode = 6'h01;
            7'b0100100: decode = 6'h02;
            7'b0110000: decode = 6'h03;
            7'b0011001: decode = 6'h04;
            7'b0010010: decode = 6'h05;
            7'b0000010: decode = 6'h06;
            7'b1111000: decode = 6'h07;
            7'b0000000: decode = 6'h08;
            7'b0010000: decode = 6'h09;
            7'b0001000: decode = 6'h0A;
            7'b0000011: decode = 6'h0B;
            7'b1000110: decode = 6'h0C;
            7'b0100001: decode = 6'h0D;
            7'b0000110: decode = 6'h0E;
            7'b0001110: decode = 6'h0F;
            7'b1111111: decode = 6'b01_0000;
            default:    decode = 6'b10_0000;
        endcase
    endfunction

    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS+7:0]   prev_q, prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
    logic [DIGITS-1:0]   sh_pt_q, sh_pt_d;
    logic [DIGITS-1:0]   sh_blk_q, sh_blk_d;
    logic [DIGITS-1:0]   sh_err_q, sh_err_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   points_q, points_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                fv_q, fv_d;
    logic [7:0]          fc_q, fc_d;

    logic [DIGITS-1:0]   sel;
    logic                sel_ok;
    logic                capture;
    logic                publish;
    logic [5:0]          dec;

    always_comb begin
        an_d     = bus.an;
        seg_d    = bus.seg;
        prev_d   = {an_q, seg_q};
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        sh_val_d = sh_val_q;
        sh_pt_d  = sh_pt_q;
        sh_blk_d = sh_blk_q;
        sh_err_d = sh_err_q;
        value_d  = value_q;
        points_d = points_q;
        blank_d  = blank_q;
        err_d    = err_q;
        fv_d     = 1'b0;
        fc_d     = fc_q;

        // one-hot check on the inverted selects: nonzero and a power of two
        sel    = ~an_q;
        sel_ok = (sel != '0) && ((sel & (sel - ONE)) == '0);
        dec    = decode(seg_q[6:0]);

        if (!sel_ok)
            cnt_d = '0;
        else if ({an_q, seg_q} == prev_q)
            cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 1'b1;
        else
            cnt_d = CW'(1);

        // counter saturates, so only the transition into STABLE_C captures
        capture = sel_ok && (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
        publish = &seen_q;

        if (publish) begin
            value_d  = sh_val_q;
            points_d = sh_pt_q;
            blank_d  = sh_blk_q;
            err_d    = sh_err_q;
            fv_d     = 1'b1;
            fc_d     = fc_q + 8'd1;
            seen_d   = '0;
        end

        // applied after the publish clear so a same-edge capture
        // lands in the next frame
        if (capture) begin
            seen_d = seen_d | sel;
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) begin
                    sh_val_d[4*i +: 4] = dec[3:0];
                    sh_blk_d[i]        = dec[4];
                    sh_err_d[i]        = dec[5];
                    sh_pt_d[i]         = ~seg_q[7];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q     <= '1;
            seg_q    <= '1;
            prev_q   <= '0;
            cnt_q    <= '0;
            seen_q   <= '0;
            sh_val_q <= '0;
            sh_pt_q  <= '0;
            sh_blk_q <= '0;
            sh_err_q <= '0;
            value_q  <= '0;
            points_q <= '0;
            blank_q  <= '1;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            an_q     <= an_d;
            seg_q    <= seg_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            sh_val_q <= sh_val_d;
            sh_pt_q  <= sh_pt_d;
            sh_blk_q <= sh_blk_d;
            sh_err_q <= sh_err_d;
            value_q  <= value_d;
            points_q <= points_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fc_q     <= fc_d;
        end
    end

    assign value       = value_q;
    assign points      = points_q;
    assign blank       = blank_q;
    assign err         = err_q;
    assign frame_valid = fv_q;
    assign frame_count = fc_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives the display bus on the
// falling edge, samples outputs on the falling edge.
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value;
    logic [7:0]  points, blank, err, frame_count;
    logic        frame_valid;
    int          checks = 0;
    int          errors = 0;
    int          fv_cnt = 0;

    seg_scan_capture_if #(.DIGITS(8)) bus ();

    seg_scan_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .value       (value),
        .points      (points),
        .blank       (blank),
        .err         (err),
        .frame_valid (frame_valid),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // each high sample is one cycle of frame_valid
    always @(negedge clk) if (frame_valid) fv_cnt <= fv_cnt + 1;

    function automatic logic [6:0] pat(input int h);
        case (h)
            0:  pat = 7'b1000000;
            1:  pat = 7'b1111001;
            2:  pat = 7'b0100100;
            3:  pat = 7'b0110000;
            4:  pat = 7'b0011001;
            5:  pat = 7'b0010010;
            6:  pat = 7'b0000010;
            7:  pat = 7'b1111000;
            8:  pat = 7'b0000000;
            9:  pat = 7'b0010000;
            10: pat = 7'b0001000;
            11: pat = 7'b0000011;
            12: pat = 7'b1000110;
            13: pat = 7'b0100001;
            14: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int k, input logic [6:0] p, input bit dp, input int n);
        logic [7:0] one;
        one = 8'd1;
        drive(~(one << k), {~dp, p}, n);
    endtask

    task automatic idle(input int n);
        drive(8'hFF, 8'hFF, n);
    endtask

    int fv0;

    initial begin
        bus.an  = 8'hFF;
        bus.seg = 8'hFF;
        @(negedge clk);
        // reset during random bus activity
        drive(8'($urandom), 8'($urandom), 1);
        drive(8'($urandom), 8'($urandom), 1);
        rst = 1'b0;
        idle(1);
        check("rst_value", value, 32'h0);
        check("rst_blank", {24'h0, blank}, 32'hFF);
        check("rst_err", {24'h0, err}, 32'h0);
        check("rst_points", {24'h0, points}, 32'h0);
        check("rst_fv", {31'h0, frame_valid}, 32'h0);
        check("rst_count", {24'h0, frame_count}, 32'h0);

        // nominal frame "1234ABCF"
        show(0, pat(15), 0, 6); show(1, pat(12), 0, 6);
        show(2, pat(11), 0, 6); show(3, pat(10), 0, 6);
        show(4, pat(4), 0, 6);  show(5, pat(3), 0, 6);
        show(6, pat(2), 0, 6);  show(7, pat(1), 0, 6);
        idle(4);
        check("nom_fv", fv_cnt, 1);
        check("nom_value", value, 32'h1234ABCF);
        check("nom_points", {24'h0, points}, 32'h0);
        check("nom_err", {24'h0, err}, 32'h0);
        check("nom_blank", {24'h0, blank}, 32'h0);
        check("nom_count", {24'h0, frame_count}, 32'd1);

        // stability filter on digit 3
        for (int k = 0; k < 8; k++) if (k != 3) show(k, pat(k), 0, 6);
        for (int i = 0; i < 20; i++) show(3, (i % 2) ? pat(8) : pat(1), 0, 1);
        show(3, pat(2), 0, 2);
        idle(6);
        check("stab_nocap_fv", fv_cnt, 1);
        check("stab_hold_value", value, 32'h1234ABCF);
        show(3, pat(2), 0, 5);
        idle(4);
        check("stab_cap_fv", fv_cnt, 2);
        check("stab_value", value, 32'h76542210);

        // blank / err / decimal point
        show(0, pat(0), 0, 5); show(1, pat(1), 0, 5);
        show(2, pat(8), 1, 5); show(3, pat(3), 0, 5);
        show(4, pat(4), 0, 5); show(5, 7'b1111111, 0, 5);
        show(6, 7'b0101010, 0, 5); show(7, pat(7), 0, 5);
        idle(4);
        check("bed_fv", fv_cnt, 3);
        check("bed_value", value, 32'h70043810);
        check("bed_points", {24'h0, points}, 32'h04);
        check("bed_blank", {24'h0, blank}, 32'h20);
        check("bed_err", {24'h0, err}, 32'h40);

        // glitched selects between digits
        for (int k = 0; k < 8; k++) begin
            show(k, pat(k + 8), 0, 5);
            drive(8'hFF, {1'b1, pat(3)}, 2);
            drive(8'hF0, {1'b1, pat(5)}, 6);
        end
        idle(4);
        check("gl_fv", fv_cnt, 4);
        check("gl_value", value, 32'hFEDCBA98);
        check("gl_err", {24'h0, err}, 32'h0);
        check("gl_blank", {24'h0, blank}, 32'h0);

        // overwrite: latest capture of digit 0 wins
        show(0, pat(3), 0, 5);
        show(0, pat(7), 0, 5);
        for (int k = 1; k < 8; k++) show(k, pat(5), 0, 5);
        idle(4);
        check("ow_value", value, 32'h55555557);
        check("ow_count", {24'h0, frame_count}, 32'd5);

        // counter wrap: 250 frames -> 255, one more -> 0
        for (int f = 0; f < 250; f++)
            for (int k = 0; k < 8; k++) show(k, pat(k), 0, 5);
        idle(4);
        check("wrap_255", {24'h0, frame_count}, 32'd255);
        for (int k = 0; k < 8; k++) show(k, pat(k), 0, 5);
        idle(4);
        check("wrap_0", {24'h0, frame_count}, 32'd0);
        check("wrap_fv", fv_cnt, 256);

        // reset mid-frame discards the partial frame
        for (int k = 0; k < 4; k++) show(k, pat(9), 0, 5);
        fv0 = fv_cnt;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("mr_count", {24'h0, frame_count}, 32'd0);
        check("mr_value", value, 32'h0);
        check("mr_blank", {24'h0, blank}, 32'hFF);
        for (int k = 4; k < 8; k++) show(k, pat(k), 0, 5);
        idle(6);
        check("mr_nopub", fv_cnt, fv0);
        for (int k = 0; k < 4; k++) show(k, pat(k), 0, 5);
        idle(4);
        check("mr_pub", fv_cnt, fv0 + 1);
        check("mr_count1", {24'h0, frame_count}, 32'd1);
        check("mr_value1", value, 32'h76543210);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Receive-side companion to the team's active-low seven-segment decoder: it monitors a multiplexed display bus (digit-select lines plus shared segment lines) and reconstructs the hex value, decimal points and blank/error status of every digit.
It is used for on-board loopback checks of display drivers and as a self-checking monitor in system benches.
A complete frame is published once every digit has been captured stably.

Parameters:
DIGITS, 8, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
an  input  DIGITS  digit selects, active-low; exactly one low bit selects a digit
seg  input  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=p (decimal point)
value  output  4*DIGITS  decoded hex nibble per digit; digit k occupies bits [4k+3:4k]
points  output  DIGITS  1 = decimal point lit on digit k
blank  output  DIGITS  1 = digit k had all of a..g off
err  output  DIGITS  1 = digit k showed an unrecognised a..g pattern
frame_valid  output  1  one-cycle pulse when value/points/blank/err are updated
frame_count  output  8  number of frames published; wraps 255->0

Behaviour:
- Reset, synchronous, active-high. Clears all state.
  - Outputs after reset: value=0, points=0, blank=all ones, err=0, frame_valid=0, frame_count=0.
  - Internal state after reset: seen-mask cleared, stability counter cleared, shadow registers cleared.
  - Reset asserted mid-frame discards any partial frame.
- Input stage: an and seg are registered once on every edge. All later logic uses the registered copies.
- Stability counter:
  - Increments, saturating at STABLE_CYCLES, while the registered {an,seg} equals its previous value.
  - Any change reloads the counter to 1.
- Selector validity: an is valid only if exactly one bit is 0. All-ones (inter-digit blanking) and multi-low patterns are invalid.
  - An invalid an reloads the counter to 0 and inhibits capture.
- Capture:
  - Occurs on the edge where the counter reaches STABLE_CYCLES with a valid an selecting digit k.
  - Fires exactly once per stable period; holding the pattern longer does not re-capture.
  - Writes shadow nibble, point, blank and err for digit k, and sets seen[k].
  - Recapturing the same digit before frame completion overwrites its shadow; latest wins.
- Decode of the active-low {g,f,e,d,c,b,a} pattern:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111: blank=1, nibble 0, err=0.
  - Any other pattern: err=1, nibble 0, blank=0.
  - points[k] = NOT seg[7], independent of the a..g decode.
- Frame publish:
  - Happens on the edge after seen becomes all ones.
  - Copies all shadows to the outputs, pulses frame_valid high for one cycle, increments frame_count and clears seen.
  - A capture on the same edge as the publish counts toward the next frame.
- Outputs hold their last published values between frames and never change except at publish or reset.
- Scan order is irrelevant; digits may be visited in any order and repeatedly.

Test Plan:
- Reset: assert rst for 2 cycles during random bus activity -> value=0, blank=8'hFF, err=0, frame_valid=0, frame_count=0.
- Nominal frame: scan digits 0..7 showing "1234ABCF" (digit0='F' … digit7='1'), each held 6 cycles, all dp off -> one frame_valid pulse, value=32'h1234ABCF, points=0, err=0, frame_count=1.
- Stability filter: toggle seg on digit 3 every cycle for 20 cycles, then hold 0100100 for 2 cycles -> no capture, no frame_valid. Then hold 5 cycles -> digit 3 captured as 2.
- Blank/err/dp: digit 5 shows 1111111, digit 6 shows 0101010, digit 2 shows '8' with seg[7]=0 -> blank[5]=1, err[6]=1, value nibble 6=0, value nibble 2=8, points[2]=1.
- Glitched selects: insert an=8'hFF and an=8'hF0 between digits -> ignored, and the frame completes with correct values.
- Overwrite and wrap:
  - Capture digit 0 as '3', then '7', before completing the frame -> nibble 0 = 7.
  - Run 256 frames -> frame_count wraps to 0.
  - Assert rst mid-frame (4 digits seen) -> no publish until a full 8 new digits are captured.
